// File: rtl/selector_table_writer_if.sv
// rtl/selector_table_writer_if.sv - entry write handshake between producer and table writer
// Carries one (address, data) table entry per transfer under valid/ready.
interface selector_table_writer_if #(
  parameter int AW = 4,
  parameter int DW = 3
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/selector_table_writer.sv
// rtl/selector_table_writer.sv - builds the packed address/data table read by the selector stage
// New addresses take the next free slot; repeated addresses overwrite data in place.
module selector_table_writer #(
  parameter int SIZE = 16,
  parameter int K    = 8,
  localparam int AW  = $clog2(SIZE),
  localparam int DW  = $clog2(K),
  localparam int EW  = AW + DW,
  localparam int CW  = $clog2(K) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          finish_i,
  selector_table_writer_if.slave        wr,
  output logic [EW*K-1:0]               table_out_o,
  output logic [CW-1:0]                 count_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [K];
  logic [DW-1:0] data_q [K];

  logic          accept;
  logic          hit;
  logic [DW-1:0] hit_idx;

  assign wr.wr_ready = (state_q == S_FILL) && (count_q < CW'(K)) && !start_i;
  assign accept      = wr.wr_valid && wr.wr_ready;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Descending scan so the lowest-index occupied match wins.
    for (int i = K - 1; i >= 0; i--) begin
      if ((CW'(i) < count_q) && (addr_q[i] == wr.wr_addr)) begin
        hit     = 1'b1;
        hit_idx = DW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (state_q == S_FILL) begin
      if (accept && !hit) count_d = count_q + CW'(1);
      if (finish_i || (count_d == CW'(K))) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      for (int i = 0; i < K; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (start_i) begin
      state_q <= S_FILL;
      count_q <= '0;
      for (int i = 0; i < K; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        if (hit) begin
          data_q[hit_idx] <= wr.wr_data;
        end else begin
          addr_q[count_q[DW-1:0]] <= wr.wr_addr;
          data_q[count_q[DW-1:0]] <= wr.wr_data;
        end
      end
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign table_out_o[g*EW +: EW] = {addr_q[g], data_q[g]};
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == S_FILL);
  assign done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_selector_table_writer.sv
// tb/tb_selector_table_writer.sv - scoreboard bench for selector_table_writer
// Stimulus updates a slot-list model and queues expectations; a monitor compares them.
module tb_selector_table_writer;

  localparam int AW = 4;
  localparam int DW = 3;
  localparam int K  = 8;
  localparam int EW = AW + DW;

  typedef struct {
    logic             rdy;
    logic [EW*K-1:0]  tbl;
    logic [3:0]       cnt;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic finish = 1'b0;
  logic [EW*K-1:0] table_out;
  logic [3:0]      count;
  logic            busy, done;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic [AW-1:0] m_addr [K];
  logic [DW-1:0] m_data [K];
  int m_cnt = 0;
  int m_state = 0;

  selector_table_writer_if #(.AW(AW), .DW(DW)) wr_if ();

  selector_table_writer #(.SIZE(16), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .finish_i    (finish),
    .wr          (wr_if),
    .table_out_o (table_out),
    .count_o     (count),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    for (int i = 0; i < K; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
  end

  function automatic logic [EW*K-1:0] pack_tbl();
    logic [EW*K-1:0] t;
    t = '0;
    for (int i = 0; i < K; i++) t[i*EW +: EW] = {m_addr[i], m_data[i]};
    return t;
  endfunction

  task automatic clear_model();
    m_cnt = 0;
    for (int i = 0; i < K; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   found;
    @(posedge clk);
    #1;
    rst = r; start = s; finish = f;
    wr_if.wr_valid = v; wr_if.wr_addr = a; wr_if.wr_data = d;
    e.rdy = (m_state == 1) && (m_cnt < K) && !s;
    if (r) begin
      m_state = 0;
      clear_model();
    end else if (s) begin
      m_state = 1;
      clear_model();
    end else if (m_state == 1) begin
      if (v && e.rdy) begin
        found = 0;
        for (int i = 0; i < m_cnt; i++) begin
          if (!found && m_addr[i] == a) begin
            found = 1;
            m_data[i] = d;
          end
        end
        if (!found) begin
          m_addr[m_cnt] = a;
          m_data[m_cnt] = d;
          m_cnt++;
        end
      end
      if (f || m_cnt == K) m_state = 2;
    end
    e.tbl  = pack_tbl();
    e.cnt  = 4'(m_cnt);
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic chk_post(input exp_t p);
    chk("table_out", 64'(table_out), 64'(p.tbl));
    chk("count", 64'(count), 64'(p.cnt));
    chk("busy", 64'(busy), 64'(p.busy));
    chk("done", 64'(done), 64'(p.done));
  endtask

  // Monitor: wr_ready is checked against the entry for the coming edge,
  // registered outputs against the entry of the edge just taken.
  initial begin
    exp_t cur, prev;
    bit   have_prev;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (have_prev) chk_post(prev);
      have_prev = 0;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("wr_ready", 64'(wr_if.wr_ready), 64'(cur.rdy));
        prev = cur;
        have_prev = 1;
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd2, 3'd1);
    step(0, 0, 0, 1, 4'd3, 3'd2);

    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 4'(i + 3), 3'(i));
    step(0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd5, 3'd2);
    step(0, 0, 0, 1, 4'd9, 3'd4);
    step(0, 0, 0, 1, 4'd5, 3'd6);
    step(0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd1, 3'd1);
    step(0, 0, 1, 1, 4'd2, 3'd3);
    step(0, 0, 0, 1, 4'd4, 3'd4);
    step(0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 4'(15 - i), 3'(i));
    step(0, 1, 0, 1, 4'd3, 3'd3);
    step(0, 0, 0, 1, 4'd7, 3'd5);
    step(0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 4'(i), 3'(i + 1));
    step(1, 0, 0, 1, 4'd8, 3'd2);
    step(0, 0, 0, 1, 4'd8, 3'd2);

    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           a, 3'($urandom_range(0, 7)));
    end
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
